elevator_trip_scheduler: RTL and testbench

ELEVATOR_TRIP_SCHEDULER -- requirements
Module: elevator_trip_scheduler

---
 rtl/elevator_trip_scheduler.sv | 144 ++++++++++++++
 tb/tb_elevator_trip_scheduler.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/elevator_trip_scheduler.sv
// Car-park elevator trip scheduler: entry and exit request FIFOs, a leakage-aware
// fair arbiter, and a valid/ready trip handshake followed by a completion wait.
module elevator_trip_scheduler #(
  parameter int DEPTH      = 4,
  parameter int FAIR_LIMIT = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_req,
  input  logic [15:0] in_plate,
  input  logic [2:0]  in_floor,
  input  logic        out_req,
  input  logic [15:0] out_plate,
  input  logic [2:0]  out_floor,
  input  logic        leakage,
  input  logic [2:0]  leakage_floor,
  output logic        trip_valid,
  input  logic        trip_ready,
  output logic        trip_dir,
  output logic [15:0] trip_plate,
  output logic [2:0]  trip_floor,
  input  logic        trip_done,
  output logic [2:0]  in_count,
  output logic [2:0]  out_count,
  output logic        in_full,
  output logic        out_full,
  output logic        busy,
  output logic        req_drop
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int STK_W = (FAIR_LIMIT > 0) ? $clog2(FAIR_LIMIT + 1) : 1;
  localparam logic [2:0]       DEPTH_C = 3'(DEPTH);
  localparam logic [STK_W-1:0] FAIR_C  = STK_W'(FAIR_LIMIT);

  typedef enum logic [1:0] {IDLE, ISSUE, BUSY} state_t;

  state_t             state;
  logic [STK_W-1:0]   out_streak;

  logic [18:0]        in_mem  [DEPTH];
  logic [18:0]        out_mem [DEPTH];
  logic [PTR_W-1:0]   in_wr, in_rd, out_wr, out_rd;

  logic               in_push, out_push, in_pop, out_pop;
  logic               in_elig, out_elig, gnt_in, gnt_out;
  logic [18:0]        in_head, out_head;

  assign in_head  = in_mem[in_rd];
  assign out_head = out_mem[out_rd];

  // Full check uses the registered count, so a pop in the same cycle does not make room.
  assign in_push  = in_req  && (in_floor  != 3'd0) && !in_full;
  assign out_push = out_req && (out_floor != 3'd0) && !out_full;

  always_comb begin
    in_elig  = (in_count != 3'd0) &&
               !(leakage && (leakage_floor != 3'd0) && (in_head[2:0] == leakage_floor));
    out_elig = (out_count != 3'd0) &&
               !(leakage && (leakage_floor != 3'd0) && (out_head[2:0] == leakage_floor));
    gnt_in   = in_elig && (!out_elig || (out_streak == FAIR_C));
    gnt_out  = out_elig && !gnt_in;
    in_pop   = (state == IDLE) && gnt_in;
    out_pop  = (state == IDLE) && gnt_out;
  end

  // Queue storage holds data only; occupancy is tracked by the reset pointers/counts.
  always_ff @(posedge clock) begin
    if (in_push)  in_mem[in_wr]   <= {in_plate, in_floor};
    if (out_push) out_mem[out_wr] <= {out_plate, out_floor};
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      in_wr     <= '0;
      in_rd     <= '0;
      out_wr    <= '0;
      out_rd    <= '0;
      in_count  <= 3'd0;
      out_count <= 3'd0;
      in_full   <= 1'b0;
      out_full  <= 1'b0;
      req_drop  <= 1'b0;
    end else begin
      if (in_push)  in_wr  <= in_wr + 1'b1;
      if (in_pop)   in_rd  <= in_rd + 1'b1;
      if (out_push) out_wr <= out_wr + 1'b1;
      if (out_pop)  out_rd <= out_rd + 1'b1;
      in_count  <= in_count + 3'(in_push) - 3'(in_pop);
      out_count <= out_count + 3'(out_push) - 3'(out_pop);
      in_full   <= ((in_count + 3'(in_push) - 3'(in_pop)) == DEPTH_C);
      out_full  <= ((out_count + 3'(out_push) - 3'(out_pop)) == DEPTH_C);
      req_drop  <= (in_req  && ((in_floor  == 3'd0) || in_full)) ||
                   (out_req && ((out_floor == 3'd0) || out_full));
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state      <= IDLE;
      out_streak <= '0;
      trip_valid <= 1'b0;
      trip_dir   <= 1'b0;
      trip_plate <= 16'd0;
      trip_floor <= 3'd0;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (gnt_in || gnt_out) begin
            state      <= ISSUE;
            trip_valid <= 1'b1;
            busy       <= 1'b1;
            trip_dir   <= gnt_in;
            trip_plate <= gnt_in ? in_head[18:3] : out_head[18:3];
            trip_floor <= gnt_in ? in_head[2:0]  : out_head[2:0];
            if (gnt_in)
              out_streak <= '0;
            else if (out_streak != FAIR_C)
              out_streak <= out_streak + 1'b1;
          end
        end
        ISSUE: begin
          if (trip_ready) begin
            state      <= BUSY;
            trip_valid <= 1'b0;
          end
        end
        BUSY: begin
          if (trip_done) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state      <= IDLE;
          trip_valid <= 1'b0;
          busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_elevator_trip_scheduler.sv
// Directed bench for elevator_trip_scheduler: single trip, illegal floor, overflow,
// fairness, leakage blocking and mid-trip reset.
module tb_elevator_trip_scheduler;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        in_req = 1'b0, out_req = 1'b0;
  logic [15:0] in_plate = '0, out_plate = '0;
  logic [2:0]  in_floor = '0, out_floor = '0;
  logic        leakage = 1'b0;
  logic [2:0]  leakage_floor = '0;
  logic        trip_valid, trip_dir, trip_ready = 1'b0, trip_done = 1'b0;
  logic [15:0] trip_plate;
  logic [2:0]  trip_floor, in_count, out_count;
  logic        in_full, out_full, busy, req_drop;

  int checks = 0;
  int errors = 0;

  elevator_trip_scheduler #(.DEPTH(4), .FAIR_LIMIT(2)) dut (
    .clock(clock), .reset(reset),
    .in_req(in_req), .in_plate(in_plate), .in_floor(in_floor),
    .out_req(out_req), .out_plate(out_plate), .out_floor(out_floor),
    .leakage(leakage), .leakage_floor(leakage_floor),
    .trip_valid(trip_valid), .trip_ready(trip_ready), .trip_dir(trip_dir),
    .trip_plate(trip_plate), .trip_floor(trip_floor), .trip_done(trip_done),
    .in_count(in_count), .out_count(out_count), .in_full(in_full), .out_full(out_full),
    .busy(busy), .req_drop(req_drop)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_trip(input logic dir, input logic [15:0] plate, input logic [2:0] floor);
    int n = 0;
    while (trip_valid !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    chk("trip_valid_wait", trip_valid, 1);
    chk("trip_dir", trip_dir, dir);
    chk("trip_plate", trip_plate, plate);
    chk("trip_floor", trip_floor, floor);
    trip_ready = 1'b1;
    tick();
    trip_ready = 1'b0;
    chk("busy_after_ready", busy, 1);
    chk("valid_after_ready", trip_valid, 0);
    trip_done = 1'b1;
    tick();
    trip_done = 1'b0;
    chk("busy_after_done", busy, 0);
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    chk("rst_valid", trip_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_counts", {in_count, out_count}, 0);
    chk("rst_full", {in_full, out_full}, 0);
    chk("rst_drop", req_drop, 0);
    chk("rst_trip", {trip_dir, trip_plate, trip_floor}, 0);
    reset = 1'b1;
    tick();

    // Single entry trip
    in_req = 1'b1; in_plate = 16'h9423; in_floor = 3'd3;
    tick();
    in_req = 1'b0;
    chk("single_count1", in_count, 1);
    chk("single_novalid", trip_valid, 0);
    tick();
    chk("single_valid", trip_valid, 1);
    chk("single_dir", trip_dir, 1);
    chk("single_plate", trip_plate, 16'h9423);
    chk("single_floor", trip_floor, 3);
    chk("single_count0", in_count, 0);
    chk("single_busy", busy, 1);
    tick();
    chk("single_hold_valid", trip_valid, 1);
    chk("single_hold_plate", trip_plate, 16'h9423);
    trip_ready = 1'b1;
    tick();
    trip_ready = 1'b0;
    chk("single_busy_state", {trip_valid, busy}, 2'b01);
    trip_done = 1'b1;
    tick();
    trip_done = 1'b0;
    chk("single_idle", busy, 0);
    chk("single_counts", {in_count, out_count}, 0);

    // Illegal floor
    in_req = 1'b1; in_plate = 16'h1234; in_floor = 3'd0;
    tick();
    in_req = 1'b0;
    chk("illegal_drop", req_drop, 1);
    chk("illegal_count", in_count, 0);
    tick();
    chk("illegal_drop_pulse", req_drop, 0);
    chk("illegal_idle", trip_valid, 0);

    // Overflow while busy
    out_req = 1'b1; out_plate = 16'h1111; out_floor = 3'd7;
    tick();
    out_req = 1'b0;
    tick();
    chk("ovf_exit_valid", {trip_valid, trip_dir, trip_plate}, {2'b10, 16'h1111});
    trip_ready = 1'b1;
    tick();
    trip_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      in_req = 1'b1; in_plate = 16'(i); in_floor = 3'(i);
      tick();
      if (i == 4) begin
        chk("ovf_full4", in_full, 1);
        chk("ovf_nodrop4", req_drop, 0);
      end
    end
    in_req = 1'b0;
    chk("ovf_drop5", req_drop, 1);
    chk("ovf_count", in_count, 4);
    chk("ovf_still_busy", busy, 1);
    trip_done = 1'b1;
    tick();
    trip_done = 1'b0;
    // Push into a full queue on the same edge it pops: still rejected
    in_req = 1'b1; in_plate = 16'h0099; in_floor = 3'd6;
    tick();
    in_req = 1'b0;
    chk("fullpop_drop", req_drop, 1);
    chk("fullpop_count", in_count, 3);
    chk("fullpop_notfull", in_full, 0);
    do_trip(1'b1, 16'h0001, 3'd1);
    do_trip(1'b1, 16'h0002, 3'd2);
    do_trip(1'b1, 16'h0003, 3'd3);
    do_trip(1'b1, 16'h0004, 3'd4);
    chk("ovf_drained", {in_count, out_count}, 0);

    // Fairness: exit, exit, entry, exit
    out_req = 1'b1; out_plate = 16'hA001; out_floor = 3'd1;
    in_req = 1'b1; in_plate = 16'hB005; in_floor = 3'd5;
    tick();
    in_req = 1'b0;
    out_plate = 16'hA002; out_floor = 3'd2;
    tick();
    out_plate = 16'hA004; out_floor = 3'd4;
    tick();
    out_req = 1'b0;
    chk("fair_counts", {in_count, out_count}, {3'd1, 3'd2});
    do_trip(1'b0, 16'hA001, 3'd1);
    do_trip(1'b0, 16'hA002, 3'd2);
    do_trip(1'b1, 16'hB005, 3'd5);
    do_trip(1'b0, 16'hA004, 3'd4);

    // Leakage blocks the exit head on floor 2
    leakage = 1'b1; leakage_floor = 3'd2;
    out_req = 1'b1; out_plate = 16'hC002; out_floor = 3'd2;
    in_req = 1'b1; in_plate = 16'hD006; in_floor = 3'd6;
    tick();
    out_req = 1'b0; in_req = 1'b0;
    tick();
    chk("leak_entry_first", {trip_valid, trip_dir, trip_plate}, {2'b11, 16'hD006});
    leakage = 1'b0;
    tick();
    chk("leak_not_withdrawn", {trip_valid, trip_plate}, {1'b1, 16'hD006});
    do_trip(1'b1, 16'hD006, 3'd6);
    do_trip(1'b0, 16'hC002, 3'd2);

    // Reset in ISSUE with two requests still queued
    out_req = 1'b1; out_plate = 16'hE001; out_floor = 3'd1;
    in_req = 1'b1; in_plate = 16'hF003; in_floor = 3'd3;
    tick();
    in_req = 1'b0;
    out_plate = 16'hE002; out_floor = 3'd2;
    tick();
    out_req = 1'b0;
    chk("pre_rst_issue", {trip_valid, trip_plate}, {1'b1, 16'hE001});
    chk("pre_rst_counts", {in_count, out_count}, {3'd1, 3'd1});
    reset = 1'b0;
    tick();
    chk("mid_rst_valid", trip_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_counts", {in_count, out_count}, 0);
    reset = 1'b1;
    trip_done = 1'b1;
    tick();
    trip_done = 1'b0;
    tick();
    tick();
    chk("post_rst_idle", {trip_valid, busy}, 0);
    chk("post_rst_counts", {in_count, out_count}, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
